// File: rtl/fetch_queue.sv
// Four-lane circular instruction buffer between fetch and decode.
// Up to four entries enter and four leave per cycle; flushD empties the queue.
module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               push_cnt,
    input  logic [IW-1:0]            instrF1,
    input  logic [IW-1:0]            instrF2,
    input  logic [IW-1:0]            instrF3,
    input  logic [IW-1:0]            instrF4,
    input  logic [AW-1:0]            pcF1,
    input  logic [AW-1:0]            pcF2,
    input  logic [AW-1:0]            pcF3,
    input  logic [AW-1:0]            pcF4,
    input  logic                     stallD,
    input  logic                     flushD,
    output logic [IW-1:0]            instrD1,
    output logic [IW-1:0]            instrD2,
    output logic [IW-1:0]            instrD3,
    output logic [IW-1:0]            instrD4,
    output logic [AW-1:0]            pcD1,
    output logic [AW-1:0]            pcD2,
    output logic [AW-1:0]            pcD3,
    output logic [AW-1:0]            pcD4,
    output logic                     validD1,
    output logic                     validD2,
    output logic                     validD3,
    output logic                     validD4,
    output logic                     fetch_stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] instrMem [DEPTH];
    logic [AW-1:0] pcMem    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [IW-1:0] laneInstr [4];
    logic [AW-1:0] lanePc    [4];
    logic [2:0]    offered;
    logic [2:0]    acc;
    logic [2:0]    pop;

    assign laneInstr[0] = instrF1;
    assign laneInstr[1] = instrF2;
    assign laneInstr[2] = instrF3;
    assign laneInstr[3] = instrF4;
    assign lanePc[0]    = pcF1;
    assign lanePc[1]    = pcF2;
    assign lanePc[2]    = pcF3;
    assign lanePc[3]    = pcF4;

    // Acceptance looks at the current count only, so a pop in the same cycle
    // never frees room for the push it coincides with.
    always_comb begin
        offered = (push_cnt <= 3'd4) ? push_cnt : 3'd0;
        acc     = fetch_stall ? 3'd0 : offered;
        pop     = 3'd0;
        if (!stallD) begin
            pop = (count >= CW'(4)) ? 3'd4 : count[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flushD) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(acc);
            count <= count + CW'(acc) - CW'(pop);
        end
    end

    // Storage has no reset; only pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (!flushD) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < acc) begin
                    instrMem[tail + PW'(k)] <= laneInstr[k];
                    pcMem[tail + PW'(k)]    <= lanePc[k];
                end
            end
        end
    end

    assign instrD1 = instrMem[head];
    assign instrD2 = instrMem[head + PW'(1)];
    assign instrD3 = instrMem[head + PW'(2)];
    assign instrD4 = instrMem[head + PW'(3)];
    assign pcD1    = pcMem[head];
    assign pcD2    = pcMem[head + PW'(1)];
    assign pcD3    = pcMem[head + PW'(2)];
    assign pcD4    = pcMem[head + PW'(3)];

    assign validD1     = (count >= CW'(1));
    assign validD2     = (count >= CW'(2));
    assign validD3     = (count >= CW'(3));
    assign validD4     = (count >= CW'(4));
    assign fetch_stall = (count > CW'(DEPTH - 4));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic checked
// against a queue-based model of the fetch/decode buffer.
module tb_fetch_queue;

    localparam int DEPTH = 16;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [2:0]    push_cnt;
    logic [IW-1:0] instrF [4];
    logic [AW-1:0] pcF    [4];
    logic          stallD;
    logic          flushD;
    logic [IW-1:0] instrD [4];
    logic [AW-1:0] pcD    [4];
    logic [3:0]    validD;
    logic          fetch_stall;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_instr_q[$];
    logic [AW-1:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .push_cnt(push_cnt),
        .instrF1(instrF[0]), .instrF2(instrF[1]), .instrF3(instrF[2]), .instrF4(instrF[3]),
        .pcF1(pcF[0]), .pcF2(pcF[1]), .pcF3(pcF[2]), .pcF4(pcF[3]),
        .stallD(stallD), .flushD(flushD),
        .instrD1(instrD[0]), .instrD2(instrD[1]), .instrD3(instrD[2]), .instrD4(instrD[3]),
        .pcD1(pcD[0]), .pcD2(pcD[1]), .pcD3(pcD[2]), .pcD4(pcD[3]),
        .validD1(validD[0]), .validD2(validD[1]), .validD3(validD[2]), .validD4(validD[3]),
        .fetch_stall(fetch_stall), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs from a negedge, update the model at the posedge,
    // and return at the following negedge. acc reports how many lanes the model took.
    task automatic drive(input int cnt, input logic [AW-1:0] base, input logic stall,
                         input logic flush, output int acc);
        int n_acc;
        int n_pop;
        push_cnt = 3'(cnt);
        for (int k = 0; k < 4; k++) begin
            pcF[k]    = base + AW'(4 * k);
            instrF[k] = $urandom;
        end
        stallD = stall;
        flushD = flush;
        n_acc = (exp_q.size() > DEPTH - 4) ? 0 : ((cnt <= 4) ? cnt : 0);
        n_pop = stall ? 0 : ((exp_q.size() < 4) ? exp_q.size() : 4);
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            exp_instr_q.delete();
            acc = 0;
        end else begin
            for (int k = 0; k < n_pop; k++) begin
                void'(exp_q.pop_front());
                void'(exp_instr_q.pop_front());
            end
            for (int k = 0; k < n_acc; k++) begin
                exp_q.push_back(pcF[k]);
                exp_instr_q.push_back(instrF[k]);
            end
            acc = n_acc;
        end
        @(negedge clk);
        push_cnt = 3'd0;
        flushD   = 1'b0;
    endtask

    task automatic drain();
        int a;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive(0, 0, 1'b0, 1'b0, a);
    endtask

    task automatic test_reset();
        int a;
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (validD !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", validD); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_fstall got %b exp 0", fetch_stall); end
        drive(3, 32'h40, 1'b1, 1'b0, a);
        checks++; if (count !== 3) begin errors++; $display("FAIL pre_reset_count got %0d exp 3", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 0) begin errors++; $display("FAIL async_reset_count got %0d exp 0", count); end
        checks++; if (validD !== 4'b0000) begin errors++; $display("FAIL async_reset_valid got %b exp 0000", validD); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL async_reset_fstall got %b exp 0", fetch_stall); end
        #1 reset = 1'b0;
        exp_q.delete();
        exp_instr_q.delete();
        @(negedge clk);
        checks++; if (count !== 0) begin errors++; $display("FAIL post_reset_count got %0d exp 0", count); end
    endtask

    task automatic test_single_group();
        int a;
        drive(4, 32'h100, 1'b0, 1'b0, a);
        checks++; if (validD !== 4'b1111) begin errors++; $display("FAIL single_valid got %b exp 1111", validD); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pcD[i] !== 32'h100 + AW'(4 * i) || instrD[i] !== exp_instr_q[i]) begin
                errors++; $display("FAIL single_lane%0d got pc %0h exp %0h", i, pcD[i], 32'h100 + 4 * i);
            end
        end
        drive(0, 0, 1'b0, 1'b0, a);
        checks++; if (validD !== 4'b0000) begin errors++; $display("FAIL single_drain_valid got %b exp 0000", validD); end
        checks++; if (count !== 0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_fill_full();
        int a;
        for (int i = 1; i <= 4; i++) begin
            drive(4, 32'h200 + AW'(16 * i), 1'b1, 1'b0, a);
            checks++; if (count !== CW'(4 * i)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", i, count, 4 * i); end
            checks++; if (fetch_stall !== (i == 4)) begin errors++; $display("FAIL fill_fstall%0d got %b exp %b", i, fetch_stall, i == 4); end
        end
        drive(4, 32'h2A0, 1'b1, 1'b0, a);
        checks++; if (count !== 16) begin errors++; $display("FAIL full_ignore_count got %0d exp 16", count); end
        drive(0, 0, 1'b0, 1'b0, a);
        checks++; if (count !== 12) begin errors++; $display("FAIL release_count got %0d exp 12", count); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL release_fstall got %b exp 0", fetch_stall); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pcD[i] !== 32'h220 + AW'(4 * i)) begin errors++; $display("FAIL release_lane%0d got %0h exp %0h", i, pcD[i], 32'h220 + 4 * i); end
        end
        drain();
    endtask

    task automatic test_wrap_partial();
        int sizes[6] = '{3, 3, 3, 3, 3, 2};
        logic [AW-1:0] push_pc = 32'h1000;
        logic [AW-1:0] next_pc = 32'h1000;
        int idx = 0;
        int a;
        int cyc = 0;
        logic stall;
        while ((idx < 6 || exp_q.size() > 0) && cyc < 60) begin
            stall = (idx < 6) ? cyc[0] : 1'b0;
            checks++;
            for (int i = 0; i < 4; i++) begin
                if (validD[i] !== (exp_q.size() > i)) begin
                    errors++; $display("FAIL wrap_valid%0d got %b size %0d", i, validD[i], exp_q.size()); break;
                end
            end
            if (!stall) begin
                for (int i = 0; i < 4 && i < exp_q.size(); i++) begin
                    checks++;
                    if (pcD[i] !== next_pc) begin errors++; $display("FAIL wrap_order got %0h exp %0h", pcD[i], next_pc); end
                    next_pc += 4;
                end
            end
            if (idx < 6) begin
                drive(sizes[idx], push_pc, stall, 1'b0, a);
                if (a == sizes[idx]) begin
                    push_pc += AW'(4 * a);
                    idx++;
                end
            end else begin
                drive(0, 0, stall, 1'b0, a);
            end
            cyc++;
        end
        checks++; if (next_pc !== 32'h1000 + 17 * 4) begin errors++; $display("FAIL wrap_delivered got %0h exp %0h", next_pc, 32'h1000 + 17 * 4); end
    endtask

    task automatic test_flush();
        int a;
        drive(4, 32'h400, 1'b1, 1'b0, a);
        drive(4, 32'h410, 1'b1, 1'b0, a);
        drive(1, 32'h420, 1'b1, 1'b0, a);
        checks++; if (count !== 9) begin errors++; $display("FAIL flush_setup got %0d exp 9", count); end
        drive(4, 32'h430, 1'b1, 1'b1, a);
        checks++; if (count !== 0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (validD !== 4'b0000) begin errors++; $display("FAIL flush_valid got %b exp 0000", validD); end
        drive(2, 32'h500, 1'b1, 1'b0, a);
        checks++; if (validD !== 4'b0011) begin errors++; $display("FAIL post_flush_valid got %b exp 0011", validD); end
        checks++; if (pcD[0] !== 32'h500 || pcD[1] !== 32'h504) begin
            errors++; $display("FAIL post_flush_pc got %0h/%0h exp 500/504", pcD[0], pcD[1]);
        end
        drain();
    endtask

    task automatic test_push_pop();
        int a;
        logic [AW-1:0] want [4] = '{32'h310, 32'h314, 32'h318, 32'h31C};
        drive(4, 32'h300, 1'b1, 1'b0, a);
        drive(2, 32'h310, 1'b1, 1'b0, a);
        checks++; if (count !== 6) begin errors++; $display("FAIL pp_setup got %0d exp 6", count); end
        drive(2, 32'h318, 1'b0, 1'b0, a);
        checks++; if (count !== 4) begin errors++; $display("FAIL pp_count got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pcD[i] !== want[i]) begin errors++; $display("FAIL pp_lane%0d got %0h exp %0h", i, pcD[i], want[i]); end
        end
        drain();
    endtask

    task automatic test_random();
        int a;
        int cnt;
        logic [AW-1:0] pc = 32'h8000;
        for (int c = 0; c < 400; c++) begin
            cnt = $urandom_range(0, 7);
            drive(cnt, pc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0), a);
            pc += 32'h20;
            checks++;
            if (count !== CW'(exp_q.size()) || fetch_stall !== (exp_q.size() > DEPTH - 4)) begin
                errors++; $display("FAIL rand_count got %0d/%b exp %0d", count, fetch_stall, exp_q.size());
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (validD[i] !== (exp_q.size() > i)) begin
                    errors++; $display("FAIL rand_valid%0d got %b exp %b", i, validD[i], exp_q.size() > i);
                end else if (exp_q.size() > i && (pcD[i] !== exp_q[i] || instrD[i] !== exp_instr_q[i])) begin
                    errors++; $display("FAIL rand_lane%0d got %0h:%0h exp %0h:%0h", i, pcD[i], instrD[i], exp_q[i], exp_instr_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        push_cnt = 3'd0;
        stallD   = 1'b0;
        flushD   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            instrF[k] = '0;
            pcF[k]    = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single_group();
        test_fill_full();
        test_wrap_partial();
        test_flush();
        test_push_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
